// File: rtl/square_asm_pkg.sv
// Shared definitions for the shift-add squarer: state encodings and default width.
package square_asm_pkg;
  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/square_asm_if.sv
// init/done handshake bundle for the squarer; master drives the request, slave returns result.
interface square_asm_if
  import square_asm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               init;
  logic [WIDTH-1:0]   A;
  logic [2*WIDTH-1:0] pp;
  logic               done;
  logic               busy;

  modport master (output init, A, input pp, done, busy);
  modport slave  (input init, A, output pp, done, busy);
endinterface

// File: rtl/square_asm_shl_mcand.sv
// Multiplicand register for the squarer: loads the zero-extended operand, then shifts left.
module shl_mcand
  import square_asm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic               shift,
  input  logic [WIDTH-1:0]   in_A,
  output logic [2*WIDTH-1:0] out_M
);
  logic [2*WIDTH-1:0] m_d;
  logic [2*WIDTH-1:0] m_q;

  // load wins over shift so a new operation never sees a stale shifted value
  always_comb begin
    m_d = m_q;
    if (ld) begin
      m_d = {{WIDTH{1'b0}}, in_A};
    end else if (shift) begin
      m_d = {m_q[2*WIDTH-2:0], 1'b0};
    end else begin
      m_d = m_q;
    end
  end

  // multiplicand storage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_q <= {(2*WIDTH){1'b0}};
    end else begin
      m_q <= m_d;
    end
  end

  assign out_M = m_q;
endmodule

// File: rtl/square_asm.sv
// Sequential squarer pp = A*A: one multiplier bit per clock over a fixed WIDTH-cycle STEP phase.
module square_asm
  import square_asm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        resetn,
  square_asm_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_d, state_q;
  logic [WIDTH-1:0]   mplier_d, mplier_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [2*WIDTH-1:0] pp_d, pp_q;
  logic               done_d, done_q;
  logic               busy_d, busy_q;
  logic               mcand_ld_s;
  logic               mcand_shift_s;
  logic [2*WIDTH-1:0] mcand_s;

  shl_mcand #(.WIDTH(WIDTH)) u_mcand (
    .clk    (clk),
    .resetn (resetn),
    .ld     (mcand_ld_s),
    .shift  (mcand_shift_s),
    .in_A   (bus.A),
    .out_M  (mcand_s)
  );

  // FSM next state plus datapath updates for mplier, cnt and the accumulator
  always_comb begin
    state_d       = state_q;
    mplier_d      = mplier_q;
    cnt_d         = cnt_q;
    pp_d          = pp_q;
    mcand_ld_s    = 1'b0;
    mcand_shift_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        mplier_d   = bus.A;
        pp_d       = {(2*WIDTH){1'b0}};
        cnt_d      = {CNT_W{1'b0}};
        mcand_ld_s = 1'b1;
        state_d    = S_STEP;
      end
      S_STEP: begin
        if (mplier_q[0]) begin
          pp_d = pp_q + mcand_s;
        end else begin
          pp_d = pp_q;
        end
        mcand_shift_s = 1'b1;
        mplier_d      = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // status flags are decoded from the upcoming state so they line up with it as flops
  always_comb begin
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // state, datapath and status registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      pp_q     <= {(2*WIDTH){1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      pp_q     <= pp_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pp   = pp_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_square_asm.sv
// Self-checking bench for square_asm: cycle-level behavioural model plus directed and random squares.
module tb_square_asm;
  localparam int W = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;

  square_asm_if #(.WIDTH(W)) bus ();

  square_asm #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase = cycles since an init was accepted, -1 when idle.
  int          phase = -1;
  logic [15:0] op_a = 16'd0;
  logic [31:0] last_res = 32'd0;

  always @(posedge clk) begin
    if (!resetn) begin
      phase    = -1;
      last_res = 32'd0;
    end else if (phase < 0) begin
      if (bus.init) phase = 0;
    end else begin
      if (phase == 0) op_a = bus.A;
      phase = phase + 1;
      if (phase == 17) last_res = 32'(op_a) * 32'(op_a);
      if (phase == 18) phase = -1;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    chk("busy", {31'd0, bus.busy}, {31'd0, (phase >= 0)});
    chk("done", {31'd0, bus.done}, {31'd0, (phase == 17)});
    if (phase < 0 || phase == 17) chk("pp", bus.pp, last_res);
    if (prev_done) chk("done_two_cycles", {31'd0, bus.done}, 32'd0);
    prev_done = bus.done;
  end

  task automatic wait_done(input int budget, input bit scramble, input int chg_at,
                           input logic [15:0] chg_val, output int c, output int bcnt);
    c = 0;
    bcnt = bus.busy ? 1 : 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (bus.busy) bcnt++;
      if (c == chg_at) bus.A = chg_val;
      if (scramble && c >= 1) begin
        bus.A    = 16'($urandom);
        bus.init = 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        if (scramble) bus.init = 1'b0;
        break;
      end
      if (c > budget) begin
        chk("timeout", 32'(c), 32'd17);
        break;
      end
    end
  endtask

  task automatic do_op(input logic [15:0] a, input bit scramble,
                       output logic [31:0] res, output int lat, output int bsy);
    @(negedge clk);
    bus.A    = a;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    wait_done(40, scramble, -1, 16'd0, lat, bsy);
    res = bus.pp;
  endtask

  logic [31:0] res;
  int lat, bsy, c;

  initial begin
    bus.init = 1'b0;
    bus.A    = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_pp", bus.pp, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    resetn = 1'b1;

    // 1: small operand, latency and busy length
    do_op(16'h0003, 1'b0, res, lat, bsy);
    chk("sq3", res, 32'h0000_0009);
    chk("latency", 32'(lat), 32'd17);
    chk("busy_len", 32'(bsy), 32'd18);

    // 2: extremes
    do_op(16'hFFFF, 1'b0, res, lat, bsy);
    chk("sqFFFF", res, 32'hFFFE_0001);
    do_op(16'h00FF, 1'b0, res, lat, bsy);
    chk("sq00FF", res, 32'h0000_FE01);

    // 3: zero and one, done is one cycle wide
    do_op(16'h0000, 1'b0, res, lat, bsy);
    chk("sq0", res, 32'h0000_0000);
    @(negedge clk);
    chk("done_w0", {31'd0, bus.done}, 32'd0);
    do_op(16'h0001, 1'b0, res, lat, bsy);
    chk("sq1", res, 32'h0000_0001);
    @(negedge clk);
    chk("done_w1", {31'd0, bus.done}, 32'd0);

    // 4: init held across two runs, A changes mid-run
    @(negedge clk);
    bus.A    = 16'd5;
    bus.init = 1'b1;
    wait_done(40, 1'b0, 4, 16'd7, c, bsy);
    chk("held_first", bus.pp, 32'd25);
    wait_done(40, 1'b0, 4, 16'd9, c, bsy);
    bus.init = 1'b0;
    chk("held_second", bus.pp, 32'd49);
    chk("held_gap", 32'(c), 32'd19);

    // 5: reset on the 8th STEP cycle aborts without done
    @(negedge clk);
    @(negedge clk);
    bus.A    = 16'hABCD;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_pp", bus.pp, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    do_op(16'h1234, 1'b0, res, lat, bsy);
    chk("sq1234", res, 32'h014B_5A90);

    // 6: random operands with A and init churn while busy
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      ra = 16'($urandom);
      do_op(ra, 1'b1, res, lat, bsy);
      chk("rand_sq", res, 32'(ra) * 32'(ra));
      if (($urandom_range(0, 3)) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
